// File: rtl/bcd_scan_pkg.sv
// Purpose: shared types and active-low seven-segment patterns for the BCD scan display.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package bcd_scan_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Purpose: BCD digit to active-low seven-segment decoder; non-decimal codes show a dash.
// Latency: combinational.
// Backpressure: none.
// Ports: i_bcd - 4-bit digit in; o_seg_n - segments {g,f,e,d,c,b,a}, active low.
module bcd_to_seg7
  import bcd_scan_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg_n = SEG_0;
      4'd1:    o_seg_n = SEG_1;
      4'd2:    o_seg_n = SEG_2;
      4'd3:    o_seg_n = SEG_3;
      4'd4:    o_seg_n = SEG_4;
      4'd5:    o_seg_n = SEG_5;
      4'd6:    o_seg_n = SEG_6;
      4'd7:    o_seg_n = SEG_7;
      4'd8:    o_seg_n = SEG_8;
      4'd9:    o_seg_n = SEG_9;
      default: o_seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Purpose: time-multiplexed BCD display scanner with per-frame snapshot and blank slot.
// Latency: outputs decode registered state only; digits_in appears at the next frame_start.
// Backpressure: en low freezes every register; no input is ever dropped or stalled upstream.
// Ports: clk, reset (sync, active high), en, digits_in[4*N-1:0] (digit 0 in [3:0]);
//        an_n (one-hot low digit select), seg_n {g,f,e,d,c,b,a} low, dig_idx, frame_start.
// Option: define BCD_SCAN_LZ_BLANK_EN to blank leading zeros (digit 0 always shown).
module bcd_scan_display
  import bcd_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [6:0]                    seg_n,
  output logic [$clog2(NUM_DIGITS)-1:0] dig_idx,
  output logic                          frame_start
);

  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_dig_idx;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic                    r_frame_start;

  logic   w_cnt_wrap;
  logic   w_snap_load;
  bcd_t   w_cur_bcd;
  logic [6:0] w_dec_seg_n;
  logic   w_blank;

  assign w_cnt_wrap  = (r_cnt == CNT_LAST);
  // Snapshot on the last cycle of the last digit so a whole frame shows one coherent value.
  assign w_snap_load = en && w_cnt_wrap && (r_dig_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_dig_idx     <= '0;
      r_snap        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_snap_load;
      if (en) begin
        r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
        if (w_cnt_wrap) begin
          r_dig_idx <= (r_dig_idx == IDX_LAST) ? '0 : r_dig_idx + 1'b1;
        end
      end
      if (w_snap_load) begin
        r_snap <= digits_in;
      end
    end
  end

  assign w_cur_bcd = r_snap[{r_dig_idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .i_bcd   (w_cur_bcd),
    .o_seg_n (w_dec_seg_n)
  );

`ifdef BCD_SCAN_LZ_BLANK_EN
  // A digit is a leading zero when it and every more significant digit are zero.
  assign w_blank = (r_dig_idx != '0) && ((r_snap >> {r_dig_idx, 2'b00}) == '0);
`else
  assign w_blank = 1'b0;
`endif

  // cnt==0 is a dark slot between digits so the previous digit's segments do not ghost.
  assign an_n        = ((r_cnt == '0) || w_blank) ? '1
                                                  : ~(NUM_DIGITS'(1) << r_dig_idx);
  assign seg_n       = w_blank ? SEG_OFF : w_dec_seg_n;
  assign dig_idx     = r_dig_idx;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_bcd_scan_display.sv
module tb_bcd_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic [1:0]  dig_idx;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

`ifdef BCD_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  bcd_scan_display #(.NUM_DIGITS(4), .DWELL_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .digits_in   (digits_in),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dig_idx     (dig_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; digits_in = 16'h0000;
    tick(2);
    chk("rst_an",  16'(an_n), 16'hF);
    chk("rst_seg", 16'(seg_n), 16'(7'b1000000));
    chk("rst_idx", 16'(dig_idx), 16'd0);
    chk("rst_fs",  16'(frame_start), 16'd0);

    // Frame 1: snapshot still zero. State counter s = cycles since en rose.
    reset = 1'b0; en = 1'b1; digits_in = 16'h1234;          // s=0
    chk("f1_an_s0", 16'(an_n), 16'hF);
    tick(1);                                                 // s=1 idx0 cnt1
    chk("f1_an_s1",  16'(an_n), 16'b1110);
    chk("f1_seg_s1", 16'(seg_n), 16'(7'b1000000));
    tick(14);                                                // s=15 idx3 cnt3
    chk("f1_fs_s15", 16'(frame_start), 16'd0);
    chk("f1_seg_s15", 16'(seg_n), 16'(7'b1000000));
    tick(1);                                                 // s=16 new frame
    chk("f2_fs",     16'(frame_start), 16'd1);
    chk("f2_an_s16", 16'(an_n), 16'hF);
    chk("f2_d0_seg", 16'(seg_n), 16'(7'b0011001));
    tick(1);                                                 // s=17
    chk("f2_fs_low", 16'(frame_start), 16'd0);
    chk("f2_d0_an",  16'(an_n), 16'b1110);
    tick(12);                                                // s=29 idx3 cnt1
    chk("f2_d3_idx", 16'(dig_idx), 16'd3);
    chk("f2_d3_an",  16'(an_n), 16'b0111);
    chk("f2_d3_seg", 16'(seg_n), 16'(7'b1111001));

    // 00A5: five, dash, then zeros (blank when leading-zero suppression is on).
    digits_in = 16'h00A5;
    tick(3);                                                 // s=32
    chk("a5_fs",     16'(frame_start), 16'd1);
    chk("a5_d0_seg", 16'(seg_n), 16'(7'b0010010));
    tick(4);                                                 // s=36 idx1
    chk("a5_d1_seg", 16'(seg_n), 16'(7'b0111111));
    tick(4);                                                 // s=40 idx2
    chk("a5_d2_seg", 16'(seg_n), LZ ? 16'(7'b1111111) : 16'(7'b1000000));
    tick(4);                                                 // s=44 idx3
    chk("a5_d3_seg", 16'(seg_n), LZ ? 16'(7'b1111111) : 16'(7'b1000000));

    // Freeze at idx2 cnt1 for 10 cycles.
    tick(13);                                                // s=57
    chk("frz_pre_idx", 16'(dig_idx), 16'd2);
    chk("frz_pre_cnt", 16'(dut.r_cnt), 16'd1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("frz_fs", 16'(frame_start), 16'd0);
      chk("frz_an", 16'(an_n), LZ ? 16'hF : 16'b1011);
    end
    chk("frz_idx", 16'(dig_idx), 16'd2);
    chk("frz_cnt", 16'(dut.r_cnt), 16'd1);
    chk("frz_seg", 16'(seg_n), LZ ? 16'(7'b1111111) : 16'(7'b1000000));

    // Mid-frame input change stays invisible until the next snapshot.
    en = 1'b1; digits_in = 16'h1111;                         // still s=57
    tick(7);                                                 // s=64
    chk("m_fs",     16'(frame_start), 16'd1);
    chk("m_d0_seg", 16'(seg_n), 16'(7'b1111001));
    tick(5);                                                 // s=69 idx1
    digits_in = 16'h9999;
    tick(4);                                                 // s=73 idx2
    chk("m_d2_seg", 16'(seg_n), 16'(7'b1111001));
    tick(6);                                                 // s=79 idx3 cnt3
    chk("m_d3_seg", 16'(seg_n), 16'(7'b1111001));
    chk("m_d3_fs",  16'(frame_start), 16'd0);
    tick(1);                                                 // s=80
    chk("m_new_fs",  16'(frame_start), 16'd1);
    chk("m_new_seg", 16'(seg_n), 16'(7'b0010000));

    // Reset mid-frame at idx2 cnt2.
    tick(10);                                                // s=90
    chk("r_pre_idx", 16'(dig_idx), 16'd2);
    chk("r_pre_cnt", 16'(dut.r_cnt), 16'd2);
    reset = 1'b1;
    tick(1);
    chk("r_idx", 16'(dig_idx), 16'd0);
    chk("r_cnt", 16'(dut.r_cnt), 16'd0);
    chk("r_an",  16'(an_n), 16'hF);
    chk("r_seg", 16'(seg_n), 16'(7'b1000000));

    // Reset wins over a pending snapshot load.
    reset = 1'b0;                                            // s=0
    tick(15);                                                // s=15 idx3 cnt3
    chk("rl_pre_idx", 16'(dig_idx), 16'd3);
    reset = 1'b1;
    tick(1);
    chk("rl_fs",  16'(frame_start), 16'd0);
    chk("rl_seg", 16'(seg_n), 16'(7'b1000000));
    chk("rl_idx", 16'(dig_idx), 16'd0);

    // 0070: seven in digit 1 with leading zeros above it.
    reset = 1'b0; digits_in = 16'h0070;                      // s=0
    tick(16);                                                // s=16
    chk("z_fs",     16'(frame_start), 16'd1);
    chk("z_d0_seg", 16'(seg_n), 16'(7'b1000000));
    tick(5);                                                 // s=21 idx1 cnt1
    chk("z_d1_an",  16'(an_n), 16'b1101);
    chk("z_d1_seg", 16'(seg_n), 16'(7'b1111000));
    tick(4);                                                 // s=25 idx2
    chk("z_d2_an",  16'(an_n), LZ ? 16'hF : 16'b1011);
    chk("z_d2_seg", 16'(seg_n), LZ ? 16'(7'b1111111) : 16'(7'b1000000));
    tick(4);                                                 // s=29 idx3
    chk("z_d3_an",  16'(an_n), LZ ? 16'hF : 16'b0111);
    chk("z_d3_seg", 16'(seg_n), LZ ? 16'(7'b1111111) : 16'(7'b1000000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
